// File: rtl/putc_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_uart
// Purpose  : Shared types and default constants for the putc UART output
//            stage: serialiser state encoding, default baud divisor, default
//            character buffer depth and the character width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pkg_uart;

  // 12 MHz system clock / 115200 baud.
  localparam int UART_CLKS_PER_BIT = 104;
  localparam int UART_FIFO_DEPTH   = 16;

  // Character width; matches the byte width of the CPU data memory.
  localparam int RAM_BYTE = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/putc_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : putc_uart_tx_if
// Purpose  : Bundles the control-unit facing push port and the status/line
//            outputs of the putc UART output stage.
// Signals  : putc      - one-cycle push strobe
//            putc_char - character to push
//            full      - character buffer full
//            idle      - buffer empty and serialiser idle
//            overflow  - sticky, a push was dropped
//            tx        - UART line, idle high
// Modports : master (control unit / top level), slave (UART output stage)
// Revision : 1.0 - initial release
// ============================================================================
interface putc_uart_tx_if
  import pkg_uart::*;
#(
  parameter int DATA_W = RAM_BYTE
) ();

  logic              putc;
  logic [DATA_W-1:0] putc_char;
  logic              full;
  logic              idle;
  logic              overflow;
  logic              tx;

  modport master (
    output putc,
    output putc_char,
    input  full,
    input  idle,
    input  overflow,
    input  tx
  );

  modport slave (
    input  putc,
    input  putc_char,
    output full,
    output idle,
    output overflow,
    output tx
  );

endinterface
`default_nettype wire

// File: rtl/putc_uart_tx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Purpose  : Synchronous single-clock FIFO. The head entry is presented
//            combinationally on pop_data; a pop advances past it.
//            Pushes into a full FIFO and pops from an empty one are ignored.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            push        - write push_data at the tail
//            push_data   - data to write
//            pop         - discard the head entry
//            pop_data    - current head entry
//            count       - number of stored entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = push && (r_count != C_CNT_FULL);
  assign w_do_pop  = pop  && (r_count != '0);

  // DEPTH is a power of two, so pointer wrap is the natural rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: entries outside head..tail are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= push_data;
    end
  end

  assign pop_data = r_mem[r_head];
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/putc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : putc_uart_tx
// Purpose  : Buffers characters from PUTC instructions and serialises them
//            as 8N1 UART frames. Back-to-back frames have no idle gap.
// Ports    : clk           - system clock
//            rst           - synchronous active-high reset
//            bus (slave)   - putc / putc_char push port,
//                            full / idle / overflow status, tx line
// Revision : 1.0 - initial release
// ============================================================================
module putc_uart_tx
  import pkg_uart::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = UART_FIFO_DEPTH,
  parameter int DATA_W       = RAM_BYTE
) (
  input  logic          clk,
  input  logic          rst,
  putc_uart_tx_if.slave bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  C_CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              r_overflow;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_pop_data;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_baud_done;
  logic              w_last_bit;

  // --------------------------------------------------------------------------
  // Character buffer
  // --------------------------------------------------------------------------
  // full comes from the registered count, so a pop in the same cycle cannot
  // make room for a push that arrives while the buffer is full.
  assign w_full  = (w_count == C_CNT_FULL);
  assign w_empty = (w_count == '0);
  assign w_push  = bus.putc && !w_full;

  byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (bus.putc_char),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .count     (w_count)
  );

  // --------------------------------------------------------------------------
  // Serialiser FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UART_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_baud_done = (r_baud_cnt == C_BAUD_LAST);
  assign w_last_bit  = (r_bit_cnt == C_BIT_LAST);

  // --------------------------------------------------------------------------
  // Serialiser FSM: next state and pop decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      UART_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = UART_START;
        end
      end
      UART_START: begin
        if (w_baud_done) begin
          w_state_next = UART_DATA;
        end
      end
      UART_DATA: begin
        if (w_baud_done && w_last_bit) begin
          w_state_next = UART_STOP;
        end
      end
      UART_STOP: begin
        // Chain straight into the next start bit when more is queued.
        if (w_baud_done) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = UART_START;
          end else begin
            w_state_next = UART_IDLE;
          end
        end
      end
      default: begin
        w_state_next = UART_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serialiser FSM: outputs
  // tx is registered from the next state so the line changes in the same
  // cycle the state does: a pop at cycle N gives a start bit from N+1.
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift_next = r_shift;
    if (w_pop) begin
      w_shift_next = w_pop_data;
    end else if ((r_state == UART_DATA) && w_baud_done) begin
      w_shift_next = r_shift >> 1;
    end

    w_tx_next = 1'b1;
    case (w_state_next)
      UART_START: w_tx_next = 1'b0;
      UART_DATA:  w_tx_next = w_shift_next[0];
      default:    w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // --------------------------------------------------------------------------
  // Baud and bit counters
  // Every state exit out of START/DATA/STOP coincides with w_baud_done, so
  // clearing on w_baud_done also starts each new state at zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if ((r_state == UART_IDLE) || w_baud_done) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
      end

      if (r_state != UART_DATA) begin
        r_bit_cnt <= '0;
      end else if (w_baud_done) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow: set by any push presented while full.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (bus.putc && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.full     = w_full;
  assign bus.idle     = w_empty && (r_state == UART_IDLE);
  assign bus.overflow = r_overflow;
  assign bus.tx       = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_putc_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_putc_uart_tx
// Purpose  : Self-checking bench for putc_uart_tx with CLKS_PER_BIT=4 and
//            FIFO_DEPTH=4. A timing-level reference model (queue of bytes,
//            earliest-pop time, current frame start) predicts tx, full, idle
//            and overflow every cycle; directed steps add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_putc_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 10 * C;

  logic clk;
  logic rst;

  putc_uart_tx_if #(.DATA_W(8)) bus ();

  putc_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D),
    .DATA_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counters and model state
  int          n_assert = 0;
  int          n_fail   = 0;
  int          t        = 0;
  bit          mvalid   = 0;
  byte unsigned q[$];
  int          next_pop_ok = -1;
  bit          fvalid = 0;
  int          cur_s  = 0;
  logic [7:0]  cur_b  = '0;
  bit          m_ovf  = 0;

  // Expected line level: frame of byte cur_b occupies cur_s .. cur_s+FRAME-1.
  function automatic logic exp_tx();
    int o;
    if (!fvalid || t < cur_s || t >= cur_s + FRAME) return 1'b1;
    o = (t - cur_s) / C;
    if (o == 0) return 1'b0;
    if (o <= 8) return cur_b[o-1];
    return 1'b1;
  endfunction

  function automatic logic exp_idle();
    return (q.size() == 0) && (t > next_pop_ok);
  endfunction

  function automatic logic exp_full();
    return q.size() == D;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  // Model update at the clock edge that ends cycle t.
  task automatic model_edge();
    bit full_m;
    if (rst) begin
      q.delete();
      next_pop_ok = t;
      fvalid      = 0;
      m_ovf       = 0;
      mvalid      = 1;
    end else if (mvalid) begin
      full_m = (q.size() == D);
      // The serialiser can take a byte whenever it is idle or finishing a stop bit.
      if (q.size() > 0 && t >= next_pop_ok) begin
        cur_b       = q.pop_front();
        cur_s       = t + 1;
        fvalid      = 1;
        next_pop_ok = t + FRAME;
      end
      if (bus.putc) begin
        if (full_m) m_ovf = 1;
        else        q.push_back(bus.putc_char);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (mvalid) begin
      chk("tx",       bus.tx,       exp_tx());
      chk("full",     bus.full,     exp_full());
      chk("idle",     bus.idle,     exp_idle());
      chk("overflow", bus.overflow, m_ovf);
    end
    @(posedge clk);
    model_edge();
    t++;
    #1;
  endtask

  task automatic push(input logic [7:0] ch);
    bus.putc      = 1'b1;
    bus.putc_char = ch;
    step();
    bus.putc      = 1'b0;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst           = 1'b1;
    bus.putc      = 1'b0;
    bus.putc_char = '0;

    // 1. Reset values and a quiet line
    repeat (3) step();
    rst = 1'b0;
    chk("rst_tx",       bus.tx,       1'b1);
    chk("rst_idle",     bus.idle,     1'b1);
    chk("rst_full",     bus.full,     1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    idle_n(50);

    // 2. Single byte 0x41: start bit two cycles after the push, idle at +42
    push(8'h41);
    idle_n(1);
    chk("single_start", bus.tx, 1'b0);
    idle_n(39);
    chk("single_stop_busy", bus.idle, 1'b0);
    idle_n(1);
    chk("single_idle", bus.idle, 1'b1);
    idle_n(5);

    // 3. Back-to-back frames
    push(8'h48);
    push(8'h69);
    push(8'h0A);
    idle_n(38);
    chk("b2b_stop1", bus.tx, 1'b1);
    idle_n(2);
    chk("b2b_start2", bus.tx, 1'b0);
    idle_n(82);
    chk("b2b_idle", bus.idle, 1'b1);

    // 4. Overflow: sixth push dropped
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    chk("ovf_set",  bus.overflow, 1'b1);
    chk("ovf_full", bus.full,     1'b1);
    idle_n(250);
    chk("ovf_sticky", bus.overflow, 1'b1);
    chk("ovf_drained", bus.idle, 1'b1);
    do_reset();
    chk("ovf_cleared", bus.overflow, 1'b0);

    // 5. Push against a full FIFO on the very cycle the stop bit ends
    push(8'h11);
    idle_n(3);
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    chk("fullpop_full", bus.full, 1'b1);
    guard = 0;
    while (t < next_pop_ok && guard < 200) begin
      step();
      guard++;
    end
    chk("fullpop_reached", 1'(t == next_pop_ok), 1'b1);
    push(8'hEE);
    chk("fullpop_ovf",  bus.overflow, 1'b1);
    chk("fullpop_full_after", bus.full, 1'b0);
    idle_n(200);
    do_reset();

    // 6. Reset during data bit 3 of 0x55 with two bytes queued
    push(8'h55);
    push(8'h66);
    push(8'h77);
    guard = 0;
    while (t < cur_s + 4 * C + 1 && guard < 100) begin
      step();
      guard++;
    end
    do_reset();
    chk("midrst_tx",       bus.tx,       1'b1);
    chk("midrst_idle",     bus.idle,     1'b1);
    chk("midrst_full",     bus.full,     1'b0);
    chk("midrst_overflow", bus.overflow, 1'b0);
    idle_n(60);

    // 7. Randomized traffic with varying push density and rare resets
    for (int ph = 0; ph < 4; ph++) begin
      int thresh;
      thresh = (ph == 0) ? 1 : (ph == 1) ? 4 : (ph == 2) ? 12 : 2;
      for (int i = 0; i < 300; i++) begin
        bus.putc      = ($urandom_range(0, 63) < thresh);
        bus.putc_char = 8'($urandom);
        rst           = ($urandom_range(0, 399) == 0);
        step();
      end
      bus.putc = 1'b0;
      rst      = 1'b0;
    end
    idle_n(200);
    chk("final_idle", bus.idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
